// File: rtl/pc_sequencer.sv
// Fetch PC owner: arbitrates branch/jump redirects against stalls and imem
// backpressure, drives the PC mux select and squashes wrong-path fetches.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC     = 32'h0,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             beq_taken_i,
  input  logic             jump_i,
  input  logic [31:0]      mux_pc_i,
  input  logic             imem_ack_i,
  output logic [1:0]       ctrl_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      next_pc_o,
  output logic             imem_req_o,
  output logic             flush_o,
  output logic [CNT_W-1:0] redirect_cnt_o
);

  typedef enum logic [1:0] {IDLE, FETCH, FLUSH} state_t;

  localparam bit         HAS_FLUSH  = (FLUSH_CYCLES > 0);
  localparam logic [3:0] FLUSH_LAST = 4'(HAS_FLUSH ? FLUSH_CYCLES - 1 : 0);

  state_t           state, state_nxt;
  logic [3:0]       flush_cnt, flush_cnt_nxt;
  logic [31:0]      pc, pc_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [31:0]      mux_aligned;
  logic             redirect;

  // Low two bits of the mux are dropped so the PC stays word aligned.
  assign mux_aligned = {mux_pc_i[31:2], 2'b00};
  assign redirect    = beq_taken_i | jump_i;

  logic unused_ok;
  assign unused_ok = ^mux_pc_i[1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      flush_cnt <= '0;
      pc        <= RESET_PC;
      cnt       <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
      pc        <= pc_nxt;
      cnt       <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    pc_nxt        = pc;
    cnt_nxt       = cnt;
    ctrl_o        = 2'b00;
    case (state)
      IDLE: begin
        if (start_i) state_nxt = FETCH;
      end
      FETCH: begin
        if (beq_taken_i)  ctrl_o = 2'b01;
        else if (jump_i)  ctrl_o = 2'b10;
        if (redirect) begin
          // Redirect wins over stall and does not wait for the imem ack.
          pc_nxt = mux_aligned;
          if (cnt != '1) cnt_nxt = cnt + CNT_W'(1);
          if (HAS_FLUSH) begin
            state_nxt     = FLUSH;
            flush_cnt_nxt = FLUSH_LAST;
          end
        end else if (!stall_i && imem_ack_i) begin
          pc_nxt = mux_aligned;
        end
      end
      FLUSH: begin
        if (flush_cnt == 4'd0) state_nxt = FETCH;
        else                   flush_cnt_nxt = flush_cnt - 4'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign pc_o           = pc;
  assign next_pc_o      = pc + 32'd4;
  assign imem_req_o     = (state == FETCH);
  assign flush_o        = (state == FLUSH);
  assign redirect_cnt_o = cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: main instance with a 2-cycle flush and a
// second instance with no flush and a 2-bit counter for saturation.
module tb_pc_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main instance
  logic        rst, start, stall, beq, jump, ack;
  logic        mux_ovr;
  logic [31:0] mux_val, beq_tgt, jump_tgt, mux_pc;
  logic [1:0]  ctrl;
  logic [31:0] pc, next_pc;
  logic        req, flush;
  logic [15:0] rcnt;

  // small-counter instance
  logic        rst2, start2, stall2, beq2, jump2, ack2;
  logic [31:0] mux2;
  logic [1:0]  ctrl2;
  logic [31:0] pc2, next_pc2;
  logic        req2, flush2;
  logic [1:0]  rcnt2;

  int errors = 0;
  int checks = 0;

  // Bench-side PC mux: picks the candidate named by ctrl, or a forced value.
  assign mux_pc = mux_ovr ? mux_val :
                  (ctrl == 2'b01) ? beq_tgt :
                  (ctrl == 2'b10) ? jump_tgt : next_pc;

  pc_sequencer #(.RESET_PC(32'h100), .FLUSH_CYCLES(2), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .stall_i(stall),
    .beq_taken_i(beq), .jump_i(jump), .mux_pc_i(mux_pc), .imem_ack_i(ack),
    .ctrl_o(ctrl), .pc_o(pc), .next_pc_o(next_pc), .imem_req_o(req),
    .flush_o(flush), .redirect_cnt_o(rcnt)
  );

  pc_sequencer #(.RESET_PC(32'h0), .FLUSH_CYCLES(0), .CNT_W(2)) dut2 (
    .clk_i(clk), .rst_i(rst2), .start_i(start2), .stall_i(stall2),
    .beq_taken_i(beq2), .jump_i(jump2), .mux_pc_i(mux2), .imem_ack_i(ack2),
    .ctrl_o(ctrl2), .pc_o(pc2), .next_pc_o(next_pc2), .imem_req_o(req2),
    .flush_o(flush2), .redirect_cnt_o(rcnt2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; start = 0; stall = 0; beq = 0; jump = 0; ack = 1;
    mux_ovr = 0; mux_val = '0; beq_tgt = '0; jump_tgt = '0;
    rst2 = 1; start2 = 0; stall2 = 0; beq2 = 0; jump2 = 0; ack2 = 1; mux2 = '0;

    // reset
    tick; tick;
    chk("rst_pc", pc, 32'h100);
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_cnt", 32'(rcnt), 32'd0);
    chk("idle_ctrl", 32'(ctrl), 32'd0);

    // 1: start then advance
    rst = 0; start = 1;
    tick; start = 0;
    chk("t1_req", 32'(req), 32'd1);
    chk("t1_pc0", pc, 32'h100);
    chk("t1_nextpc", next_pc, 32'h104);
    tick; chk("t1_pc1", pc, 32'h104);
    tick; chk("t1_pc2", pc, 32'h108);

    // 2: stall 3 cycles, then backpressure 2 cycles
    stall = 1; #1;
    chk("t2_ctrl_stall", 32'(ctrl), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin stall = 0; ack = 0; end
      tick;
      chk($sformatf("t2_hold%0d", i), pc, 32'h108);
      chk($sformatf("t2_ctrl%0d", i), 32'(ctrl), 32'd0);
    end
    ack = 1;
    tick; chk("t2_adv", pc, 32'h10C);

    // 3: simultaneous beq + jump + stall
    beq = 1; jump = 1; stall = 1; beq_tgt = 32'h200; jump_tgt = 32'h300; #1;
    chk("t3_ctrl", 32'(ctrl), 32'd1);
    tick; beq = 0; jump = 0; stall = 0;
    chk("t3_pc", pc, 32'h200);
    chk("t3_flush0", 32'(flush), 32'd1);
    chk("t3_req0", 32'(req), 32'd0);
    chk("t3_cnt", 32'(rcnt), 32'd1);

    // 4: jump during flush is ignored
    jump = 1; mux_ovr = 1; mux_val = 32'h400; #1;
    chk("t4_ctrl", 32'(ctrl), 32'd0);
    tick; jump = 0; mux_ovr = 0;
    chk("t4_pc", pc, 32'h200);
    chk("t4_cnt", 32'(rcnt), 32'd1);
    chk("t3_flush1", 32'(flush), 32'd1);
    chk("t3_req1", 32'(req), 32'd0);
    tick;
    chk("t3_flush_end", 32'(flush), 32'd0);
    chk("t3_req_back", 32'(req), 32'd1);
    chk("t3_pc_back", pc, 32'h200);
    tick; chk("t3_adv", pc, 32'h204);

    // 5: unaligned jump target
    jump = 1; jump_tgt = 32'h203; #1;
    chk("t5_ctrl_jump", 32'(ctrl), 32'd2);
    tick; jump = 0;
    chk("t5_align", pc, 32'h200);
    chk("t5_cnt", 32'(rcnt), 32'd2);
    tick; tick;
    chk("t5_fetch", 32'(req), 32'd1);

    // 5: wrap of next_pc, then 6: reset in the first flush cycle
    beq = 1; beq_tgt = 32'hFFFF_FFFC;
    tick; beq = 0;
    chk("t5_pc_top", pc, 32'hFFFF_FFFC);
    chk("t5_wrap", next_pc, 32'h0);
    chk("t6_in_flush", 32'(flush), 32'd1);
    rst = 1;
    tick; rst = 0;
    chk("t6_pc", pc, 32'h100);
    chk("t6_flush", 32'(flush), 32'd0);
    chk("t6_cnt", 32'(rcnt), 32'd0);
    chk("t6_req", 32'(req), 32'd0);
    tick;
    chk("t6_idle_hold", pc, 32'h100);

    // saturation on the 2-bit counter, no flush bubbles
    rst2 = 0; start2 = 1;
    tick; start2 = 0;
    chk("s_req", 32'(req2), 32'd1);
    beq2 = 1; mux2 = 32'h40;
    for (int i = 0; i < 4; i++) begin
      tick;
      chk($sformatf("s_cnt%0d", i), 32'(rcnt2), (i < 3) ? 32'(i + 1) : 32'd3);
      chk($sformatf("s_noflush%0d", i), 32'(flush2), 32'd0);
    end
    chk("s_pc", pc2, 32'h40);
    chk("s_req_kept", 32'(req2), 32'd1);
    beq2 = 0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
